// File: rtl/alu_pkg.sv
// Shared ALU operation codes and execute-unit FSM states.
// Imported by the ALU-control decoder and the execute unit.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [3:0] OP_ILLEGAL_MIN = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  function automatic logic is_shift_op(
    input logic [3:0] op
  );
    return (op == OP_SLL) || (op == OP_SRL) ||
           (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operand/result valid-ready bundle of the execute ALU.
// master = issuing side, slave = the ALU.
interface alu_exec_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_operation;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal_op;

  modport master (
    output in_valid,
    output alu_operation,
    output operand_a,
    output operand_b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  result,
    input  zero,
    input  illegal_op
  );

  modport slave (
    input  in_valid,
    input  alu_operation,
    input  operand_a,
    input  operand_b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output result,
    output zero,
    output illegal_op
  );
endinterface

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter; acc is the accumulator value
// after the step taken on the coming edge.
module alu_serial_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               dir,
  input  logic               arith,
  input  logic [XLEN-1:0]    data,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    acc
);

  logic [XLEN-1:0]    acc_q;
  logic [SHAMT_W-1:0] cnt;
  logic               dir_q;
  logic               arith_q;
  logic [XLEN-1:0]    src;
  logic               s_dir;
  logic               s_arith;

  always_comb begin
    src     = load ? data  : acc_q;
    s_dir   = load ? dir   : dir_q;
    s_arith = load ? arith : arith_q;
    if (s_dir)
      acc = {s_arith & src[XLEN-1], src[XLEN-1:1]};
    else
      acc = {src[XLEN-2:0], 1'b0};
  end

  assign busy = (cnt != '0);
  assign done = load ? (shamt == SHAMT_W'(1))
                     : (cnt == SHAMT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      dir_q   <= dir;
      arith_q <= arith;
      if (shamt != '0) begin
        acc_q <= acc;
        cnt   <= shamt - SHAMT_W'(1);
      end else begin
        acc_q <= data;
        cnt   <= '0;
      end
    end else if (busy) begin
      acc_q <= acc;
      cnt   <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ops plus a serial shifter
// behind a valid/ready handshake with registered result.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  alu_exec_unit_if.slave bus
);

  localparam int SHAMT_W = $clog2(XLEN);

  state_t             state;
  state_t             state_nx;
  logic               accept;
  logic [SHAMT_W-1:0] shamt;
  logic               sh_load;
  logic               sh_busy;
  logic               sh_done;
  logic [XLEN-1:0]    sh_acc;
  logic [XLEN-1:0]    alu_res;
  logic               illegal;
  logic [XLEN-1:0]    a;
  logic [XLEN-1:0]    b;

  assign a     = bus.operand_a;
  assign b     = bus.operand_b;
  assign shamt = b[SHAMT_W-1:0];

  assign bus.in_ready = !rst && (state != SHIFT) &&
                        (!bus.out_valid || bus.out_ready);
  assign accept  = bus.in_valid && bus.in_ready;
  assign sh_load = accept &&
                   is_shift_op(bus.alu_operation) &&
                   (shamt != '0);
  assign bus.out_valid = (state == DONE);

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (sh_load),
    .dir   (bus.alu_operation != OP_SLL),
    .arith (bus.alu_operation == OP_SRA),
    .data  (a),
    .shamt (shamt),
    .busy  (sh_busy),
    .done  (sh_done),
    .acc   (sh_acc)
  );

  always_comb begin
    alu_res = '0;
    illegal = 1'b0;
    case (bus.alu_operation)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      // Shifts only land here when the amount is zero.
      OP_SLL,
      OP_SRL,
      OP_SRA:  alu_res = a;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}},
                          $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept)
          state_nx = (sh_load && !sh_done) ? SHIFT : DONE;
        else if (state == DONE && bus.out_ready)
          state_nx = IDLE;
      end
      SHIFT: begin
        if (sh_done)
          state_nx = DONE;
        else if (!sh_busy)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.result     <= '0;
      bus.zero       <= 1'b0;
      bus.illegal_op <= 1'b0;
    end else if (accept && !sh_load) begin
      bus.result     <= alu_res;
      bus.zero       <= (alu_res == '0);
      bus.illegal_op <= illegal;
    end else if (sh_done) begin
      bus.result     <= sh_acc;
      bus.zero       <= (sh_acc == '0);
      bus.illegal_op <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed plus random checks of alu_exec_unit against
// an arithmetic reference model.
module tb_alu_exec_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  alu_exec_unit_if #(.XLEN(32)) bus ();

  alu_exec_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  function automatic logic [31:0] ref_res(
    input logic [3:0] op, input logic [31:0] x,
    input logic [31:0] y);
    int unsigned sh;
    sh = y % 32;
    case (op)
      0: return x + y;
      1: return x - y;
      2: return x & y;
      3: return x | y;
      4: return x ^ y;
      5: return x << sh;
      6: return x >> sh;
      7: return $signed(x) >>> sh;
      8: return ($signed(x) < $signed(y)) ? 1 : 0;
      9: return (x < y) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [3:0] op, input logic [31:0] y);
    if (op >= 5 && op <= 7 && (y % 32) != 0)
      return int'(y % 32);
    return 1;
  endfunction

  // Issue one op, wait for its result; out_ready left as is.
  task automatic run_op(input string tag,
                        input logic [3:0] op,
                        input logic [31:0] x,
                        input logic [31:0] y);
    logic [31:0] exp;
    int lat;
    int n;
    bit stall_ok;
    exp = ref_res(op, x, y);
    lat = ref_lat(op, y);
    bus.alu_operation = op;
    bus.operand_a = x;
    bus.operand_b = y;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      step();
      n++;
    end
    check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    bus.alu_operation = 4'($urandom_range(0, 15));
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    n = 1;
    stall_ok = 1'b1;
    while (!bus.out_valid && n < 40) begin
      if (bus.in_ready) stall_ok = 1'b0;
      step();
      n++;
    end
    check({tag, "_stall"}, 32'(stall_ok), 1);
    check({tag, "_latency"}, n, lat);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_zero"}, 32'(bus.zero),
          32'(exp == 0));
    check({tag, "_illegal"}, 32'(bus.illegal_op),
          32'(op >= 10));
  endtask

  initial begin
    bit never_valid;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.alu_operation = '0;
    bus.operand_a = '0;
    bus.operand_b = '0;

    step();
    step();
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_result", bus.result, 0);
    check("rst_zero", 32'(bus.zero), 0);
    check("rst_illegal", 32'(bus.illegal_op), 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 1);

    // Back-to-back ADD then SUB, one per cycle.
    bus.in_valid = 1'b1;
    bus.alu_operation = 4'd0;
    bus.operand_a = 32'h7FFF_FFFF;
    bus.operand_b = 32'd1;
    step();
    check("add_valid", 32'(bus.out_valid), 1);
    check("add_result", bus.result, 32'h8000_0000);
    check("add_zero", 32'(bus.zero), 0);
    check("add_in_ready", 32'(bus.in_ready), 1);
    bus.alu_operation = 4'd1;
    bus.operand_a = 32'd5;
    bus.operand_b = 32'd7;
    step();
    bus.in_valid = 1'b0;
    check("sub_valid", 32'(bus.out_valid), 1);
    check("sub_result", bus.result, 32'hFFFF_FFFE);
    check("sub_zero", 32'(bus.zero), 0);

    run_op("slt", 4'd8, 32'hFFFF_FFFF, 32'd1);
    run_op("sltu", 4'd9, 32'hFFFF_FFFF, 32'd1);
    run_op("sra31", 4'd7, 32'h8000_0000, 32'd31);
    run_op("sll0", 4'd5, 32'd1, 32'd0);
    run_op("srl1", 4'd6, 32'h8000_0000, 32'd1);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      run_op("rand", op, $urandom, $urandom);
    end

    // Illegal op with downstream stalled.
    bus.out_ready = 1'b0;
    run_op("illegal", 4'b1100, 32'h1234_5678,
           32'h9ABC_DEF0);
    bus.in_valid = 1'b1;
    bus.alu_operation = 4'd0;
    bus.operand_a = 32'd1;
    bus.operand_b = 32'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_valid", 32'(bus.out_valid), 1);
      check("hold_result", bus.result, 0);
      check("hold_zero", 32'(bus.zero), 1);
      check("hold_illegal", 32'(bus.illegal_op), 1);
      check("hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("drain_in_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    check("swap_valid", 32'(bus.out_valid), 1);
    check("swap_result", bus.result, 2);
    check("swap_illegal", 32'(bus.illegal_op), 0);

    // Reset in the middle of a 20-bit shift.
    step();
    bus.in_valid = 1'b1;
    bus.alu_operation = 4'd5;
    bus.operand_a = 32'd1;
    bus.operand_b = 32'd20;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("mid_shift_valid", 32'(bus.out_valid), 0);
    rst = 1'b1;
    step();
    check("abort_valid", 32'(bus.out_valid), 0);
    check("abort_result", bus.result, 0);
    check("abort_zero", 32'(bus.zero), 0);
    check("abort_illegal", 32'(bus.illegal_op), 0);
    check("abort_in_ready", 32'(bus.in_ready), 0);
    rst = 1'b0;
    never_valid = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.out_valid) never_valid = 1'b0;
    end
    check("abort_no_result", 32'(never_valid), 1);
    run_op("add_after_rst", 4'd0, 32'd2, 32'd3);

    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
